// File: rtl/r5p_tcb_arb2_if.sv
// One TCB port: a request bundle with a vld/rdy handshake and a response
// (rdt/err) that returns a fixed number of cycles after the request is transferred.
interface r5p_tcb_arb2_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  localparam int BW = DW / 8;

  // vld/rdy: a transfer happens on every cycle where vld & rdy are both high.
  // The requester holds vld and all request fields stable until that cycle.
  // rdy may depend combinationally on vld. rdt/err have no handshake of their
  // own; they are valid DLY cycles after the transfer.
  logic          vld;
  logic          wen;
  logic [AW-1:0] adr;
  logic [BW-1:0] ben;
  logic [DW-1:0] wdt;
  logic          rdy;
  logic [DW-1:0] rdt;
  logic          err;

  modport master (output vld, wen, adr, ben, wdt, input  rdy, rdt, err);
  modport slave  (input  vld, wen, adr, ben, wdt, output rdy, rdt, err);
endinterface

// File: rtl/r5p_tcb_arb2.sv
// Two-manager (IFU on m0, LSU on m1) to one-subordinate TCB arbiter.
// Grants combinationally, holds a stalled grant, and routes delayed responses by id.
module r5p_tcb_arb2 #(
  parameter int AW  = 32,
  parameter int DW  = 32,
  parameter int DLY = 1,
  parameter int RR  = 0
) (
  input  logic           clk,
  input  logic           rst,
  r5p_tcb_arb2_if.slave  m0,
  r5p_tcb_arb2_if.slave  m1,
  r5p_tcb_arb2_if.master s,
  output logic           dbg_lck,
  output logic           dbg_own,
  output logic           dbg_pri,
  output logic           dbg_sel
);

  typedef enum logic {
    ST_OPEN = 1'b0,
    ST_LOCK = 1'b1
  } state_t;

  state_t         state;
  logic           own;
  logic           pri;
  logic           sel;
  logic           trn;
  logic [1:0]     vld;
  logic [DLY-1:0] pipe_v;
  logic [DLY-1:0] pipe_id;
  logic           rsp_v;
  logic           rsp_id;

  assign vld = {m1.vld, m0.vld};

  // A locked grant wins over everything; otherwise a lone requester wins and
  // an idle bus defaults to the IFU so its fields appear on s_*.
  always_comb begin
    sel = 1'b0;
    if (state == ST_LOCK) begin
      sel = own;
    end else if (vld == 2'b11) begin
      sel = (RR != 0) ? pri : 1'b1;
    end else begin
      sel = vld[1];
    end
  end

  assign s.vld  = |vld;
  assign s.wen  = sel ? m1.wen : m0.wen;
  assign s.adr  = sel ? m1.adr : m0.adr;
  assign s.ben  = sel ? m1.ben : m0.ben;
  assign s.wdt  = sel ? m1.wdt : m0.wdt;
  assign m0.rdy = s.rdy & ~sel;
  assign m1.rdy = s.rdy &  sel;
  assign trn    = s.vld & s.rdy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_OPEN;
      own   <= 1'b0;
      pri   <= 1'b1;
    end else begin
      if (s.vld && !s.rdy) begin
        state <= ST_LOCK;
        own   <= sel;
      end else if (trn) begin
        state <= ST_OPEN;
      end
      if ((RR != 0) && trn) begin
        pri <= ~sel;
      end
    end
  end

  // Each stage carries its own id, so alternating back-to-back transfers need no bubbles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_v  <= '0;
      pipe_id <= '0;
    end else begin
      pipe_v[0]  <= trn;
      pipe_id[0] <= sel;
      for (int i = 1; i < DLY; i++) begin
        pipe_v[i]  <= pipe_v[i-1];
        pipe_id[i] <= pipe_id[i-1];
      end
    end
  end

  assign rsp_v  = pipe_v[DLY-1];
  assign rsp_id = pipe_id[DLY-1];

  assign m0.rdt = (rsp_v && !rsp_id) ? s.rdt : '0;
  assign m1.rdt = (rsp_v &&  rsp_id) ? s.rdt : '0;
  assign m0.err = rsp_v & ~rsp_id & s.err;
  assign m1.err = rsp_v &  rsp_id & s.err;

  assign dbg_lck = (state == ST_LOCK);
  assign dbg_own = own;
  assign dbg_pri = pri;
  assign dbg_sel = sel;

endmodule

// File: tb/tb_r5p_tcb_arb2.sv
// Bench for r5p_tcb_arb2: three configurations (RR0/DLY1, RR1/DLY1, RR1/DLY3)
// driven by directed sequences and random TCB managers, checked against a model.
module tb_r5p_tcb_arb2;
  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;

  typedef struct packed {
    logic [1:0]  inst;
    logic [15:0] due;
    logic        id;
  } rsp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Stimulus per instance
  logic [1:0]    vld [N];
  logic [1:0]    wen [N];
  logic [AW-1:0] adr [N][2];
  logic [3:0]    ben [N][2];
  logic [DW-1:0] wdt [N][2];
  logic          s_rdy [N];
  logic [DW-1:0] s_rdt [N];
  logic          s_err [N];

  // Observed DUT outputs
  logic [N-1:0][1:0]         got_rdy;
  logic [N-1:0][1:0][DW-1:0] got_rdt;
  logic [N-1:0][1:0]         got_err;
  logic [N-1:0]              got_svld;
  logic [N-1:0]              got_swen;
  logic [N-1:0][AW-1:0]      got_sadr;
  logic [N-1:0][3:0]         got_sben;
  logic [N-1:0][DW-1:0]      got_swdt;
  logic [N-1:0]              got_lck;
  logic [N-1:0]              got_own;
  logic [N-1:0]              got_pri;
  logic [N-1:0]              got_sel;

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int G_RR  = (g == 0) ? 0 : 1;
    localparam int G_DLY = (g == 2) ? 3 : 1;
    r5p_tcb_arb2_if #(.AW(AW), .DW(DW)) m0_if ();
    r5p_tcb_arb2_if #(.AW(AW), .DW(DW)) m1_if ();
    r5p_tcb_arb2_if #(.AW(AW), .DW(DW)) s_if ();

    assign m0_if.vld = vld[g][0];
    assign m0_if.wen = wen[g][0];
    assign m0_if.adr = adr[g][0];
    assign m0_if.ben = ben[g][0];
    assign m0_if.wdt = wdt[g][0];
    assign m1_if.vld = vld[g][1];
    assign m1_if.wen = wen[g][1];
    assign m1_if.adr = adr[g][1];
    assign m1_if.ben = ben[g][1];
    assign m1_if.wdt = wdt[g][1];
    assign s_if.rdy  = s_rdy[g];
    assign s_if.rdt  = s_rdt[g];
    assign s_if.err  = s_err[g];

    assign got_rdy[g]  = {m1_if.rdy, m0_if.rdy};
    assign got_rdt[g]  = {m1_if.rdt, m0_if.rdt};
    assign got_err[g]  = {m1_if.err, m0_if.err};
    assign got_svld[g] = s_if.vld;
    assign got_swen[g] = s_if.wen;
    assign got_sadr[g] = s_if.adr;
    assign got_sben[g] = s_if.ben;
    assign got_swdt[g] = s_if.wdt;

    r5p_tcb_arb2 #(.AW(AW), .DW(DW), .DLY(G_DLY), .RR(G_RR)) dut (
      .clk     (clk),
      .rst     (rst),
      .m0      (m0_if),
      .m1      (m1_if),
      .s       (s_if),
      .dbg_lck (got_lck[g]),
      .dbg_own (got_own[g]),
      .dbg_pri (got_pri[g]),
      .dbg_sel (got_sel[g])
    );
  end

  // Model state and scoreboard
  logic       m_lck [N];
  logic       m_own [N];
  logic       m_pri [N];
  logic [1:0] req_act [N];
  rsp_t       exp_q[$];
  int         cyc = 0;
  int         p_vld [2];
  int         p_rdy;
  int         p_err;
  int         n_checks = 0;
  int         n_fail = 0;

  function automatic int cfg_rr(int i);
    return (i == 0) ? 0 : 1;
  endfunction

  function automatic int cfg_dly(int i);
    return (i == 2) ? 3 : 1;
  endfunction

  function automatic string tg(string n, int i);
    return $sformatf("%s_i%0d", n, i);
  endfunction

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  // Who owns the port this cycle, straight from the arbitration rules.
  function automatic logic model_sel(int i);
    if (m_lck[i]) return m_own[i];
    if (vld[i] == 2'b11) return (cfg_rr(i) != 0) ? m_pri[i] : 1'b1;
    if (vld[i] == 2'b10) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    for (int i = 0; i < N; i++) begin
      m_lck[i]   = 1'b0;
      m_own[i]   = 1'b0;
      m_pri[i]   = 1'b1;
      req_act[i] = 2'b00;
    end
  endtask

  task automatic drive_idle(input logic [DW-1:0] rdt, input logic err);
    for (int i = 0; i < N; i++) begin
      vld[i]   = 2'b00;
      wen[i]   = 2'b00;
      s_rdy[i] = 1'b1;
      s_rdt[i] = rdt;
      s_err[i] = err;
      for (int j = 0; j < 2; j++) begin
        adr[i][j] = '0;
        ben[i][j] = '0;
        wdt[i][j] = '0;
      end
    end
  endtask

  task automatic drive_all(input logic [1:0] v, input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                           input logic rdy, input logic [DW-1:0] rdt);
    drive_idle(rdt, 1'b0);
    for (int i = 0; i < N; i++) begin
      vld[i]    = v;
      adr[i][0] = a0;
      adr[i][1] = a1;
      s_rdy[i]  = rdy;
    end
  endtask

  // TCB managers: a request, once raised, is held unchanged until transferred.
  task automatic drive_stim();
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < 2; j++) begin
        if (!req_act[i][j]) begin
          vld[i][j] = ($urandom_range(99) < p_vld[j]);
          req_act[i][j] = vld[i][j];
          wen[i][j] = 1'($urandom_range(1));
          adr[i][j] = $urandom;
          ben[i][j] = 4'($urandom_range(15));
          wdt[i][j] = $urandom;
        end
      end
      s_rdy[i] = ($urandom_range(99) < p_rdy);
      s_rdt[i] = $urandom;
      s_err[i] = ($urandom_range(99) < p_err);
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < N; i++) begin
      logic             sel;
      logic             found;
      logic             fid;
      logic [2*DW-1:0]  e_rdt;
      logic [1:0]       e_err;
      sel   = model_sel(i);
      found = 1'b0;
      fid   = 1'b0;
      check(tg("s_vld", i), got_svld[i], |vld[i]);
      check(tg("s_req", i), {got_swen[i], got_sben[i], got_sadr[i], got_swdt[i]},
            {wen[i][sel], ben[i][sel], adr[i][sel], wdt[i][sel]});
      check(tg("m_rdy", i), got_rdy[i], sel ? {s_rdy[i], 1'b0} : {1'b0, s_rdy[i]});
      check(tg("lck", i), got_lck[i], m_lck[i]);
      check(tg("pri", i), got_pri[i], m_pri[i]);
      for (int k = 0; k < exp_q.size(); k++) begin
        if (exp_q[k].inst == 2'(i) && exp_q[k].due == 16'(cyc)) begin
          found = 1'b1;
          fid   = exp_q[k].id;
          exp_q.delete(k);
          break;
        end
      end
      e_rdt = !found ? '0 : (fid ? {s_rdt[i], 32'h0} : {32'h0, s_rdt[i]});
      e_err = !found ? 2'b00 : ((fid ? 2'b10 : 2'b01) & {2{s_err[i]}});
      check(tg("m_rdt", i), got_rdt[i], e_rdt);
      check(tg("m_err", i), got_err[i], e_err);
    end
  endtask

  task automatic update_model();
    for (int i = 0; i < N; i++) begin
      logic sel;
      logic trn;
      rsp_t e;
      sel = model_sel(i);
      trn = (vld[i] != 2'b00) && s_rdy[i];
      if (trn) begin
        e.inst = 2'(i);
        e.due  = 16'(cyc + cfg_dly(i));
        e.id   = sel;
        exp_q.push_back(e);
        req_act[i][sel] = 1'b0;
      end
      if ((vld[i] != 2'b00) && !s_rdy[i]) begin
        m_lck[i] = 1'b1;
        m_own[i] = sel;
      end else if (trn) begin
        m_lck[i] = 1'b0;
      end
      if (trn && cfg_rr(i) != 0) m_pri[i] = ~sel;
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Entered and left at 1 ns after a rising edge.
  task automatic run_phase(input int ncyc, input int pv0, input int pv1, input int pr, input int pe);
    p_vld[0] = pv0;
    p_vld[1] = pv1;
    p_rdy    = pr;
    p_err    = pe;
    repeat (ncyc) begin
      drive_stim();
      #4;
      check_all();
      update_model();
      next_cycle();
    end
  endtask

  task automatic apply_reset();
    #2;
    rst = 1'b1;
    model_reset();
    drive_idle('0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    cyc++;
  endtask

  initial begin
    drive_idle('0, 1'b0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #4;
    for (int i = 0; i < N; i++) begin
      check(tg("rst_lck", i), got_lck[i], 1'b0);
      check(tg("rst_pri", i), got_pri[i], 1'b1);
      check(tg("rst_rdt", i), got_rdt[i], 64'h0);
    end
    next_cycle();

    // IFU alone, then its response one (and three) cycles later
    drive_all(2'b01, 32'h100, 32'h0, 1'b1, 32'h0);
    #4;
    check("d_ifu_adr", got_sadr[0], 32'h100);
    check("d_ifu_rdy", got_rdy[0], 2'b01);
    next_cycle();
    drive_all(2'b00, 32'h0, 32'h0, 1'b1, 32'hCAFE);
    #4;
    check("d_ifu_rdt", got_rdt[0], {32'h0, 32'hCAFE});
    check("d_dly3_early", got_rdt[2], 64'h0);
    next_cycle();
    drive_all(2'b00, 32'h0, 32'h0, 1'b1, 32'h0);
    next_cycle();
    drive_all(2'b00, 32'h0, 32'h0, 1'b1, 32'hBEEF);
    #4;
    check("d_dly3_rdt", got_rdt[2], {32'h0, 32'hBEEF});
    next_cycle();

    // Stalled IFU keeps the port while the LSU arrives
    drive_all(2'b01, 32'h200, 32'h300, 1'b0, 32'h0);
    #4;
    check("d_lck1_adr", got_sadr[0], 32'h200);
    check("d_lck1_rdy", got_rdy[0], 2'b00);
    next_cycle();
    for (int k = 0; k < 2; k++) begin
      drive_all(2'b11, 32'h200, 32'h300, 1'b0, 32'h0);
      #4;
      check("d_lck2_adr", got_sadr[0], 32'h200);
      check("d_lck2_flag", got_lck[0], 1'b1);
      next_cycle();
    end
    drive_all(2'b11, 32'h200, 32'h300, 1'b1, 32'h0);
    #4;
    check("d_lck_trn_adr", got_sadr[0], 32'h200);
    check("d_lck_trn_rdy", got_rdy[0], 2'b01);
    next_cycle();
    drive_all(2'b10, 32'h200, 32'h300, 1'b1, 32'h0);
    #4;
    check("d_lsu_next_adr", got_sadr[0], 32'h300);
    check("d_lsu_next_rdy", got_rdy[0], 2'b10);
    next_cycle();

    // Both valid: fixed priority on inst 0, alternation on inst 1 (pri is now 0)
    for (int k = 0; k < 3; k++) begin
      drive_all(2'b11, 32'h400, 32'h500, 1'b1, 32'h0);
      #4;
      check("d_fix_rdy", got_rdy[0], 2'b10);
      check("d_rr_rdy", got_rdy[1], (k % 2 == 0) ? 2'b01 : 2'b10);
      next_cycle();
    end
    drive_all(2'b01, 32'h400, 32'h500, 1'b1, 32'h0);
    #4;
    check("d_fix_ifu_rdy", got_rdy[0], 2'b01);
    check("d_fix_ifu_adr", got_sadr[0], 32'h400);
    next_cycle();

    apply_reset();

    run_phase(400, 60, 60, 70, 30);
    run_phase(200, 100, 100, 100, 30);
    run_phase(300, 50, 50, 30, 30);
    run_phase(100, 80, 0, 80, 30);
    run_phase(3, 100, 100, 100, 50);

    // Reset with responses in flight: nothing may leak out afterwards
    apply_reset();
    for (int k = 0; k < 4; k++) begin
      drive_idle(32'hFFFF_FFFF, 1'b1);
      #4;
      for (int i = 0; i < N; i++) begin
        check(tg("post_rst_rdt", i), got_rdt[i], 64'h0);
        check(tg("post_rst_err", i), got_err[i], 2'b00);
        check(tg("post_rst_pri", i), got_pri[i], 1'b1);
        check(tg("post_rst_lck", i), got_lck[i], 1'b0);
      end
      next_cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
